// File: rtl/frame_bank_scheduler.sv
// Ping-pong scheduler: grants empty banks to the pipeline and hands full banks to the transfer engine in write order.
// Latency: request or done sampled at edge N is acted on at edge N+1; start pulses are registered.
// Backpressure: requests wait while no bank is EMPTY; extra requests while one is pending are counted and dropped.
module frame_bank_scheduler #(
    parameter int CNT_W   = 8,
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_req,
    output logic               pipe_start,
    input  logic               pipe_frame_done,
    output logic               wr_bank,
    output logic               xfer_start,
    input  logic               xfer_done,
    output logic               rd_bank,
    output logic [1:0]         bank_full,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [CNT_W-1:0]   overrun_cnt,
    output logic               proto_err
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
    typedef enum logic {W_IDLE, W_RUN} w_state_e;
    typedef enum logic {R_IDLE, R_RUN} r_state_e;

    bank_st_e           bank_st_q [2];
    bank_st_e           bank_st_d [2];
    w_state_e           w_state_q, w_state_d;
    r_state_e           r_state_q, r_state_d;
    logic               pending_q, pending_d;
    logic               last_wr_q, last_wr_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               pipe_start_q, pipe_start_d;
    logic               xfer_start_q, xfer_start_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   overrun_cnt_q, overrun_cnt_d;
    logic               proto_err_q, proto_err_d;
    logic               wr_pick, rd_pick, grant;

    always_comb begin
        bank_st_d[0]  = bank_st_q[0];
        bank_st_d[1]  = bank_st_q[1];
        w_state_d     = w_state_q;
        r_state_d     = r_state_q;
        pending_d     = pending_q;
        last_wr_d     = last_wr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        pipe_start_d  = 1'b0;
        xfer_start_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        proto_err_d   = proto_err_q;
        grant         = 1'b0;

        // Alternate banks when possible; fall back to the same bank if the other is still occupied.
        wr_pick = (bank_st_q[~last_wr_q] == B_EMPTY) ? ~last_wr_q : last_wr_q;
        if (bank_st_q[0] == B_FULL && bank_st_q[1] == B_FULL) begin
            rd_pick = ~last_wr_q;
        end else begin
            rd_pick = (bank_st_q[0] == B_FULL) ? 1'b0 : 1'b1;
        end

        case (w_state_q)
            W_IDLE: begin
                if (pipe_frame_done) begin
                    proto_err_d = 1'b1;
                end
                if (pending_q && (bank_st_q[0] == B_EMPTY || bank_st_q[1] == B_EMPTY)) begin
                    grant              = 1'b1;
                    wr_bank_d          = wr_pick;
                    last_wr_d          = wr_pick;
                    pipe_start_d       = 1'b1;
                    bank_st_d[wr_pick] = B_FILLING;
                    w_state_d          = W_RUN;
                end
            end
            default: begin
                if (pipe_frame_done) begin
                    bank_st_d[wr_bank_q] = B_FULL;
                    frame_cnt_d          = frame_cnt_q + FRAME_W'(1);
                    w_state_d            = W_IDLE;
                end
            end
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (xfer_done) begin
                    proto_err_d = 1'b1;
                end
                if (bank_st_q[0] == B_FULL || bank_st_q[1] == B_FULL) begin
                    rd_bank_d          = rd_pick;
                    xfer_start_d       = 1'b1;
                    bank_st_d[rd_pick] = B_DRAINING;
                    r_state_d          = R_RUN;
                end
            end
            default: begin
                if (xfer_done) begin
                    bank_st_d[rd_bank_q] = B_EMPTY;
                    r_state_d            = R_IDLE;
                end
            end
        endcase

        // The grant consumes the pending request before this cycle's request is captured.
        pending_d = pending_q & ~grant;
        if (frame_req) begin
            if (pending_d) begin
                if (overrun_cnt_q != '1) begin
                    overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
                end
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st_q[0]  <= B_EMPTY;
            bank_st_q[1]  <= B_EMPTY;
            w_state_q     <= W_IDLE;
            r_state_q     <= R_IDLE;
            pending_q     <= 1'b0;
            last_wr_q     <= 1'b1;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            pipe_start_q  <= 1'b0;
            xfer_start_q  <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            bank_st_q[0]  <= bank_st_d[0];
            bank_st_q[1]  <= bank_st_d[1];
            w_state_q     <= w_state_d;
            r_state_q     <= r_state_d;
            pending_q     <= pending_d;
            last_wr_q     <= last_wr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            pipe_start_q  <= pipe_start_d;
            xfer_start_q  <= xfer_start_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign pipe_start   = pipe_start_q;
    assign xfer_start   = xfer_start_q;
    assign wr_bank      = wr_bank_q;
    assign rd_bank      = rd_bank_q;
    assign bank_full[0] = (bank_st_q[0] == B_FULL) || (bank_st_q[0] == B_DRAINING);
    assign bank_full[1] = (bank_st_q[1] == B_FULL) || (bank_st_q[1] == B_DRAINING);
    assign busy         = (w_state_q != W_IDLE) || (r_state_q != R_IDLE) || pending_q;
    assign frame_cnt    = frame_cnt_q;
    assign overrun_cnt  = overrun_cnt_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: expected start pulses (bank, cycle) are queued by the stimulus
// and consumed by a monitor; status outputs are compared against hand-computed values.
module tb_frame_bank_scheduler;

    logic        clk = 1'b0;
    logic        rst, frame_req, pipe_frame_done, xfer_done;
    logic        pipe_start, wr_bank, xfer_start, rd_bank, busy, proto_err;
    logic [1:0]  bank_full;
    logic [15:0] frame_cnt;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    typedef struct {
        logic bank;
        int   cyc;
    } ev_t;

    ev_t pipe_q[$];
    ev_t xfer_q[$];
    ev_t pe, xe;

    frame_bank_scheduler #(.CNT_W(8), .FRAME_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_req       (frame_req),
        .pipe_start      (pipe_start),
        .pipe_frame_done (pipe_frame_done),
        .wr_bank         (wr_bank),
        .xfer_start      (xfer_start),
        .xfer_done       (xfer_done),
        .rd_bank         (rd_bank),
        .bank_full       (bank_full),
        .busy            (busy),
        .frame_cnt       (frame_cnt),
        .overrun_cnt     (overrun_cnt),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    // Monitor: every start pulse must match the oldest queued expectation in bank and cycle.
    always @(negedge clk) begin
        if (pipe_start) begin
            n_checks++;
            if (pipe_q.size() == 0) begin
                n_errors++;
                $display("FAIL pipe_start_unexpected: pulse at cycle %0d wr_bank %0d, required none", edge_n, wr_bank);
            end else begin
                pe = pipe_q.pop_front();
                if (wr_bank !== pe.bank || edge_n != pe.cyc) begin
                    n_errors++;
                    $display("FAIL pipe_start: got bank %0d cycle %0d, required bank %0d cycle %0d",
                             wr_bank, edge_n, pe.bank, pe.cyc);
                end
            end
        end
        if (xfer_start) begin
            n_checks++;
            if (xfer_q.size() == 0) begin
                n_errors++;
                $display("FAIL xfer_start_unexpected: pulse at cycle %0d rd_bank %0d, required none", edge_n, rd_bank);
            end else begin
                xe = xfer_q.pop_front();
                if (rd_bank !== xe.bank || edge_n != xe.cyc) begin
                    n_errors++;
                    $display("FAIL xfer_start: got bank %0d cycle %0d, required bank %0d cycle %0d",
                             rd_bank, edge_n, xe.bank, xe.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (edge_n < t) step();
    endtask

    task automatic exp_pipe(input logic b, input int c);
        ev_t e;
        e.bank = b;
        e.cyc  = c;
        pipe_q.push_back(e);
    endtask

    task automatic exp_xfer(input logic b, input int c);
        ev_t e;
        e.bank = b;
        e.cyc  = c;
        xfer_q.push_back(e);
    endtask

    task automatic req_at(input int t);
        wait_to(t);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
    endtask

    task automatic pdone_at(input int t);
        wait_to(t);
        pipe_frame_done = 1'b1;
        step();
        pipe_frame_done = 1'b0;
    endtask

    task automatic xdone_at(input int t);
        wait_to(t);
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pipe_start"}, 32'(pipe_start), 0);
        chk({tag, "_xfer_start"}, 32'(xfer_start), 0);
        chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
        chk({tag, "_rd_bank"}, 32'(rd_bank), 0);
        chk({tag, "_bank_full"}, 32'(bank_full), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        chk({tag, "_overrun_cnt"}, 32'(overrun_cnt), 0);
        chk({tag, "_proto_err"}, 32'(proto_err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_zero("reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, f, g, h;
        rst             = 1'b1;
        frame_req       = 1'b0;
        pipe_frame_done = 1'b0;
        xfer_done       = 1'b0;
        do_reset();

        // Single frame: request -> pipe_start 2 cycles later on bank 0; done -> xfer_start 2 cycles later.
        e = edge_n;
        exp_pipe(1'b0, e + 2);
        req_at(e);
        exp_xfer(1'b0, e + 12);
        pdone_at(e + 10);
        chk("t1_bank_full_after_done", 32'(bank_full), 32'b01);
        chk("t1_frame_cnt", 32'(frame_cnt), 1);
        wait_to(e + 13);
        chk("t1_bank_full_draining", 32'(bank_full), 32'b01);
        chk("t1_busy_draining", 32'(busy), 1);
        xdone_at(e + 14);
        chk("t1_bank_full_released", 32'(bank_full), 0);
        chk("t1_busy_idle", 32'(busy), 0);

        do_reset();

        // Three requests with the first transfer held: third grant waits for bank 0 to drain.
        e = edge_n;
        exp_pipe(1'b0, e + 2);
        req_at(e);
        exp_xfer(1'b0, e + 6);
        pdone_at(e + 4);
        exp_pipe(1'b1, e + 7);
        req_at(e + 5);
        pdone_at(e + 9);
        req_at(e + 10);
        wait_to(e + 13);
        chk("t2_bank_full_both", 32'(bank_full), 32'b11);
        chk("t2_frame_cnt", 32'(frame_cnt), 2);
        chk("t2_busy_blocked", 32'(busy), 1);
        chk("t2_rd_bank_first", 32'(rd_bank), 0);
        exp_pipe(1'b0, e + 17);
        exp_xfer(1'b1, e + 17);
        xdone_at(e + 15);
        chk("t2_bank_full_after_free", 32'(bank_full), 32'b10);
        pdone_at(e + 19);
        chk("t2_frame_cnt_third", 32'(frame_cnt), 3);
        exp_xfer(1'b0, e + 23);
        xdone_at(e + 21);
        xdone_at(e + 24);
        chk("t2_bank_full_drained", 32'(bank_full), 0);

        // Simultaneous pipe_frame_done and xfer_done with a request pending.
        e = edge_n;
        exp_pipe(1'b1, e + 2);
        req_at(e);
        exp_xfer(1'b1, e + 5);
        pdone_at(e + 3);
        exp_pipe(1'b0, e + 7);
        req_at(e + 5);
        req_at(e + 8);
        wait_to(e + 11);
        exp_pipe(1'b1, e + 13);
        exp_xfer(1'b0, e + 13);
        pipe_frame_done = 1'b1;
        xfer_done       = 1'b1;
        step();
        pipe_frame_done = 1'b0;
        xfer_done       = 1'b0;
        chk("t4_bank_full_simul", 32'(bank_full), 32'b01);
        chk("t4_frame_cnt_simul", 32'(frame_cnt), 5);
        pdone_at(e + 14);
        exp_xfer(1'b1, e + 18);
        xdone_at(e + 16);
        xdone_at(e + 19);
        chk("t4_frame_cnt_end", 32'(frame_cnt), 6);
        chk("t4_bank_full_end", 32'(bank_full), 0);
        chk("t4_busy_end", 32'(busy), 0);

        // Both banks blocked with frame_req held: overrun counts then saturates, no extra grant.
        e = edge_n;
        exp_pipe(1'b0, e + 2);
        req_at(e);
        exp_xfer(1'b0, e + 5);
        pdone_at(e + 3);
        exp_pipe(1'b1, e + 7);
        req_at(e + 5);
        pdone_at(e + 8);
        wait_to(e + 10);
        frame_req = 1'b1;
        wait_to(e + 50);
        chk("t5_overrun_partial", 32'(overrun_cnt), 39);
        wait_to(e + 310);
        frame_req = 1'b0;
        chk("t5_overrun_sat", 32'(overrun_cnt), 255);
        chk("t5_frame_cnt", 32'(frame_cnt), 8);
        chk("t5_bank_full_blocked", 32'(bank_full), 32'b11);
        f = edge_n;
        exp_pipe(1'b0, f + 2);
        exp_xfer(1'b1, f + 2);
        xdone_at(f);
        pdone_at(f + 3);
        exp_xfer(1'b0, f + 7);
        xdone_at(f + 5);
        xdone_at(f + 8);
        chk("t5_overrun_held", 32'(overrun_cnt), 255);
        chk("t5_frame_cnt_end", 32'(frame_cnt), 9);
        chk("t5_bank_full_end", 32'(bank_full), 0);
        chk("t5_proto_err_clean", 32'(proto_err), 0);

        // Stray xfer_done while idle, then reset in the middle of a write.
        g = edge_n;
        xdone_at(g);
        chk("t6_proto_err_set", 32'(proto_err), 1);
        chk("t6_bank_full_unchanged", 32'(bank_full), 0);
        chk("t6_busy_idle", 32'(busy), 0);
        wait_to(g + 3);
        chk("t6_proto_err_sticky", 32'(proto_err), 1);
        exp_pipe(1'b1, g + 6);
        req_at(g + 4);
        wait_to(g + 8);
        chk("t6_busy_mid_write", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("midrst");
        h = edge_n;
        exp_pipe(1'b0, h + 2);
        req_at(h);
        exp_xfer(1'b0, h + 5);
        pdone_at(h + 3);
        xdone_at(h + 7);
        chk("t6_frame_cnt_after_rst", 32'(frame_cnt), 1);
        chk("t6_bank_full_after_rst", 32'(bank_full), 0);
        pdone_at(h + 9);
        chk("t6_proto_err_pdone_idle", 32'(proto_err), 1);
        chk("t6_frame_cnt_pdone_idle", 32'(frame_cnt), 1);

        wait_to(h + 14);
        chk("pipe_queue_drained", 32'(pipe_q.size()), 0);
        chk("xfer_queue_drained", 32'(xfer_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
